seq_signed_multiplier: RTL
==========================

Name: seq_signed_multiplier

Overview:
- Multi-cycle, parametrised signed/unsigned integer multiplier for the arithmetic_modules library. Uses radix-2 shift-add over operand magnitudes, then applies a final sign correction.
- Trades the single-cycle array multiplier's area for N+1 cycles of latency.
- Has a per-transaction signed/unsigned mode and valid/ready handshakes on both sides.
- Sits between operand producers (register file / datapath controller) and result consumers in the CA datapath.

Parameters:
- N, 32, operand width in bits; product width is 2N; legal N >= 2.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands and mode present
- in_ready  output  1  block can accept operands
- a  input  N  multiplicand
- b  input  N  multiplier
- signed_mode  input  1  1 = a and b are two's complement; 0 = unsigned
- out_valid  output  1  product valid
- out_ready  input  1  consumer accepts product
- out  output  2N  product (two's complement when signed_mode = 1)

Behaviour:
- One clock (clk); reset rst_n is asynchronous and active-low.
- Reset values:
  - State = IDLE, in_ready = 1, out_valid = 0, out = 0.
  - Internal accumulator, operand registers and count = 0.
- States:
  - IDLE: in_ready = 1.
  - CALC: in_ready = 0.
  - SIGN: in_ready = 0.
  - DONE: in_ready = 0, out_valid = 1.
- Accept (edge E0): in_valid && in_ready at a rising edge, in IDLE.
  - Latch mag_a and mag_b, the N-bit magnitudes. In signed mode a negative operand is negated; in unsigned mode the operand is passed through.
  - Latch neg = signed_mode & (a[N-1] ^ b[N-1]).
  - Clear the 2N-bit accumulator, set count = 0, go to CALC.
- CALC (edges E1..EN, exactly N cycles):
  - If mag_b[0] = 1, add mag_a (zero-extended, shifted by count) into the accumulator.
  - Shift mag_b right by 1 and increment count.
  - Leave CALC after the iteration with count = N-1.
  - Zero operands still take the full N cycles; there is no early termination.
- SIGN (edge E(N+1)):
  - out <= neg ? (~acc + 1) : acc, truncated to 2N bits.
  - Set out_valid = 1 and go to DONE.
  - out_valid is first visible after edge E0+N+1.
- DONE:
  - out and out_valid are held stable until out_ready = 1.
  - On an edge with out_ready = 1: out_valid <= 0, go to IDLE. out keeps its last value.
  - No operand is accepted in the same cycle; the earliest next accept is the following edge.
  - Minimum issue interval is N+3 cycles.
- Width rules:
  - The most-negative operand -2^(N-1) has magnitude 2^(N-1), which fits in N unsigned bits.
  - (-2^(N-1)) x (-2^(N-1)) = 2^(2N-2) is representable; the result is exact for every input pair in both modes. No overflow flag.
  - A zero product with neg = 1 must yield 0 (negating 0 gives 0).
- Input side effects:
  - Operand, mode or in_valid changes outside IDLE are ignored.
  - in_valid held high in DONE has no effect until IDLE.
  - out_ready outside DONE is ignored.
- Reset mid-operation: asserting rst_n low in any state forces the reset values immediately, without waiting for clk. Any in-flight result is discarded. The first accept after release is at the first edge with rst_n = 1.

Decomposition:
- Package seq_mult_pkg holds:
  - State typedef (IDLE, CALC, SIGN, DONE), 2-bit encoding.
  - Function clog2-based count width: CNT_W = $clog2(N), minimum 1.
- One sub-module is natural: seq_mult_datapath, which holds the accumulator, shift registers, count and sign correction, with load/step/finish strobes.
- The top level holds the FSM and the handshake.

Test Plan:
- N=8, signed_mode=1, a=-3 (0xFD), b=5 -> out=0xFFF1 (-15); out_valid first high exactly 9 edges after accept.
- N=8, signed_mode=1, a=0x80, b=0x80 -> out=0x4000. With signed_mode=0, same operands -> out=0x4000. With signed_mode=0, a=0xFF, b=0xFF -> out=0xFE01.
- N=8, signed_mode=1, a=0, b=-7 -> out=0x0000.
- N=32 default, a=-1, b=0x7FFFFFFF, signed_mode=1 -> out=0xFFFFFFFF80000001. Hold out_ready=0 for 5 cycles: out and out_valid stable. Raise out_ready: out_valid=0 next edge, in_ready=1.
- Back-to-back with in_valid held high and out_ready=1: accepts spaced exactly N+3 edges apart. Operands changed mid-CALC do not affect the result.
- Assert rst_n=0 asynchronously during CALC (count=4) -> out_valid=0, in_ready=1, out=0 with no clock edge. A new transaction after release produces the correct product.

Source files
------------

// File: rtl/seq_mult_pkg.sv
// seq_mult_pkg: shared FSM state type and counter sizing for the sequential multiplier
package seq_mult_pkg;
  typedef enum logic [1:0] {IDLE, CALC, SIGN, DONE} state_t;
  function automatic int cnt_w(int n);
    return n < 2 ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/seq_signed_multiplier_if.sv
// seq_signed_multiplier_if: operand and product valid/ready handshakes of the multiplier
interface seq_signed_multiplier_if #(parameter int N = 32);
  logic in_valid, in_ready, signed_mode, out_valid, out_ready;
  logic [N-1:0] a, b;
  logic [2*N-1:0] out;
  modport master(output in_valid, a, b, signed_mode, out_ready, input in_ready, out_valid, out);
  modport slave(input in_valid, a, b, signed_mode, out_ready, output in_ready, out_valid, out);
endinterface

// File: rtl/seq_mult_datapath.sv
// seq_mult_datapath: magnitude shift-add accumulator with final sign correction
module seq_mult_datapath
  import seq_mult_pkg::*;
#(
  parameter int N = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           load,
  input  logic           step,
  input  logic           finish,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  input  logic           signed_mode,
  output logic           last,
  output logic [2*N-1:0] product
);
  localparam int CNT_W = cnt_w(N);
  logic [N-1:0] mag_a, mag_b;
  logic [2*N-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic neg;
  assign last = cnt == CNT_W'(N - 1);
  // negating the most-negative value yields 2^(N-1), which still fits N unsigned bits
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      mag_a <= '0;
      mag_b <= '0;
      acc <= '0;
      cnt <= '0;
      neg <= 1'b0;
      product <= '0;
    end else if (load) begin
      mag_a <= signed_mode && a[N-1] ? -a : a;
      mag_b <= signed_mode && b[N-1] ? -b : b;
      neg <= signed_mode & (a[N-1] ^ b[N-1]);
      acc <= '0;
      cnt <= '0;
    end else if (step) begin
      acc <= mag_b[0] ? acc + ({{N{1'b0}}, mag_a} << cnt) : acc;
      mag_b <= mag_b >> 1;
      cnt <= cnt + 1'b1;
    end else if (finish)
      product <= neg ? ~acc + 1'b1 : acc;
endmodule

// File: rtl/seq_signed_multiplier.sv
// seq_signed_multiplier: N+1 cycle signed/unsigned multiplier with valid/ready handshakes
module seq_signed_multiplier
  import seq_mult_pkg::*;
#(
  parameter int N = 32
) (
  input logic                    clk,
  input logic                    rst_n,
  seq_signed_multiplier_if.slave bus
);
  state_t state, state_nxt;
  logic load, step, finish, last;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  always_comb
    state_nxt = state == IDLE ? (bus.in_valid ? CALC : IDLE)
              : state == CALC ? (last ? SIGN : CALC)
              : state == SIGN ? DONE
              : (bus.out_ready ? IDLE : DONE);
  always_comb begin
    bus.in_ready = state == IDLE;
    bus.out_valid = state == DONE;
    load = state == IDLE && bus.in_valid;
    step = state == CALC;
    finish = state == SIGN;
  end
  seq_mult_datapath #(.N(N)) u_dp (
    .clk(clk),
    .rst_n(rst_n),
    .load(load),
    .step(step),
    .finish(finish),
    .a(bus.a),
    .b(bus.b),
    .signed_mode(bus.signed_mode),
    .last(last),
    .product(bus.out)
  );
endmodule
